// File: rtl/smdr_stack.sv
// Save-MDR store: captures the resolved M-bus into a DEPTH-entry LIFO or FIFO
// and drives the head entry back onto the active-low wired-AND M-bus.
module smdr_stack #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int FIFO_MODE = 0
) (
   input  logic                         b_clk_l,
   input  logic                         reset_l,
   input  logic [WIDTH-1:0]             mbus_l,
   input  logic                         save_l,
   input  logic                         restore_l,
   input  logic                         ena_smdr_l,
   input  logic                         clr_err_l,
   output logic [WIDTH-1:0]             mbus_out_l,
   output logic [$clog2(DEPTH+1)-1:0]   count_h,
   output logic                         empty_h,
   output logic                         full_h,
   output logic                         ovf_h,
   output logic                         unf_h
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;

   logic             do_save, do_restore;
   logic             ovf_evt, unf_evt;
   logic [PW-1:0]    top_idx, push_idx, head_idx, wr_next, rd_next;

   // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign do_save    = ~save_l;
   assign do_restore = ~restore_l;
   assign empty_h    = (count_q == '0);
   assign full_h     = (count_q == CNT_FULL);
   assign count_h    = count_q;
   assign ovf_h      = ovf_q;
   assign unf_h      = unf_q;

   assign top_idx  = PW'(count_q - 1'b1);
   assign push_idx = PW'(count_q);
   assign wr_next  = ptr_inc(wr_ptr_q);
   assign rd_next  = ptr_inc(rd_ptr_q);
   assign head_idx = (FIFO_MODE != 0) ? rd_ptr_q : top_idx;

   assign mbus_out_l = (!ena_smdr_l && !empty_h) ? mem_q[head_idx] : '1;

   always_comb begin
      mem_d    = mem_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_evt  = 1'b0;
      unf_evt  = 1'b0;
      // A save paired with a restore on an empty store degenerates to a plain save.
      if (do_save && (!do_restore || empty_h)) begin
         if (full_h) begin
            ovf_evt = 1'b1;
         end else begin
            if (FIFO_MODE != 0) begin
               mem_d[wr_ptr_q] = mbus_l;
               wr_ptr_d        = wr_next;
            end else begin
               mem_d[push_idx] = mbus_l;
            end
            count_d = count_q + 1'b1;
         end
      end else if (do_restore && !do_save) begin
         if (empty_h) begin
            unf_evt = 1'b1;
         end else begin
            if (FIFO_MODE != 0) rd_ptr_d = rd_next;
            count_d = count_q - 1'b1;
         end
      end else if (do_save && do_restore) begin
         if (FIFO_MODE != 0) begin
            mem_d[wr_ptr_q] = mbus_l;
            wr_ptr_d        = wr_next;
            rd_ptr_d        = rd_next;
         end else begin
            mem_d[top_idx] = mbus_l;
         end
      end
      ovf_d = (ovf_q & clr_err_l) | ovf_evt;
      unf_d = (unf_q & clr_err_l) | unf_evt;
   end

   always_ff @(posedge b_clk_l) begin
      if (!reset_l) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Contents are meaningless while count is zero, so storage carries no reset.
   always_ff @(posedge b_clk_l) begin
      mem_q <= mem_d;
   end

endmodule
